// File: rtl/ex_mem_hilo_stage.sv
// EX/MEM pipeline register with the architectural HI/LO register pair.
// Registers the ALU Low result (or MFHI/MFLO data) and ZeroFlag. Owns HI/LO,
// which take multiply/divide results and MTHI/MTLO data. Handles stall (hold)
// and flush (bubble) from the hazard unit.
// Optional build macro EXMEM_PERF_CNT_EN adds the RetireCount and StallCount
// performance counters.
module ex_mem_hilo_stage #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  InValid,
  input  logic [WIDTH-1:0]      High,
  input  logic [WIDTH-1:0]      Low,
  input  logic                  ZeroFlag,
  input  logic                  HiLoWrite,
  input  logic [1:0]            MoveOp,
  input  logic [WIDTH-1:0]      MoveData,
  input  logic [1:0]            ReadSel,
  input  logic                  RegWriteIn,
  input  logic [REG_ADDR_W-1:0] DestRegIn,
  input  logic                  Stall,
  input  logic                  Flush,
  output logic                  OutValid,
  output logic [WIDTH-1:0]      Result,
  output logic                  ZeroOut,
  output logic                  RegWriteOut,
  output logic [REG_ADDR_W-1:0] DestRegOut,
  output logic [WIDTH-1:0]      HiReg,
`ifdef EXMEM_PERF_CNT_EN
  output logic [WIDTH-1:0]      LoReg,
  output logic [31:0]           RetireCount,
  output logic [31:0]           StallCount
`else
  output logic [WIDTH-1:0]      LoReg
`endif
);

  localparam logic [1:0] MoveNone = 2'b00;
  localparam logic [1:0] MoveHi   = 2'b01;
  localparam logic [1:0] MoveLo   = 2'b10;
  localparam logic [1:0] ReadHi   = 2'b01;
  localparam logic [1:0] ReadLo   = 2'b10;

  logic             accept;
  logic [WIDTH-1:0] selResult;
  logic [WIDTH-1:0] hiNext;
  logic [WIDTH-1:0] loNext;

  assign accept = InValid & ~Stall & ~Flush;

  // Result mux reads HI/LO as they were before this edge, so MFHI right after
  // MULT sees the new value and an illegal read+write sees the old one.
  always_comb begin
    selResult = Low;
    case (ReadSel)
      ReadHi:  selResult = HiReg;
      ReadLo:  selResult = LoReg;
      default: selResult = Low;
    endcase
  end

  // Next HI/LO: mult/div results win over MTHI/MTLO; MoveOp 11 is a no-op.
  always_comb begin
    hiNext = HiReg;
    loNext = LoReg;
    if (HiLoWrite) begin
      hiNext = High;
      loNext = Low;
    end else if (MoveOp == MoveHi) begin
      hiNext = MoveData;
    end else if (MoveOp == MoveLo) begin
      loNext = MoveData;
    end else if (MoveOp == MoveNone) begin
      hiNext = HiReg;
    end
  end

  // EX/MEM register: hold on stall, load on accept, otherwise insert a bubble.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      OutValid    <= 1'b0;
      Result      <= '0;
      ZeroOut     <= 1'b0;
      RegWriteOut <= 1'b0;
      DestRegOut  <= '0;
    end else if (Stall) begin
      OutValid    <= OutValid;
    end else if (accept) begin
      OutValid    <= 1'b1;
      Result      <= selResult;
      ZeroOut     <= ZeroFlag;
      RegWriteOut <= RegWriteIn;
      DestRegOut  <= DestRegIn;
    end else begin
      OutValid    <= 1'b0;
      Result      <= '0;
      ZeroOut     <= 1'b0;
      RegWriteOut <= 1'b0;
      DestRegOut  <= '0;
    end
  end

  // HI/LO only change for an accepted instruction.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      HiReg <= '0;
      LoReg <= '0;
    end else if (accept) begin
      HiReg <= hiNext;
      LoReg <= loNext;
    end
  end

`ifdef EXMEM_PERF_CNT_EN
  // Free-running performance counters; both wrap naturally at 2^32.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      RetireCount <= '0;
      StallCount  <= '0;
    end else begin
      if (accept) RetireCount <= RetireCount + 32'd1;
      if (Stall)  StallCount  <= StallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_hilo_stage.sv
module tb_ex_mem_hilo_stage;

  logic        Clk;
  logic        Reset;
  logic        InValid;
  logic [31:0] High;
  logic [31:0] Low;
  logic        ZeroFlag;
  logic        HiLoWrite;
  logic [1:0]  MoveOp;
  logic [31:0] MoveData;
  logic [1:0]  ReadSel;
  logic        RegWriteIn;
  logic [4:0]  DestRegIn;
  logic        Stall;
  logic        Flush;
  logic        OutValid;
  logic [31:0] Result;
  logic        ZeroOut;
  logic        RegWriteOut;
  logic [4:0]  DestRegOut;
  logic [31:0] HiReg;
  logic [31:0] LoReg;
`ifdef EXMEM_PERF_CNT_EN
  logic [31:0] RetireCount;
  logic [31:0] StallCount;
`endif

  int total = 0;
  int bad   = 0;

  ex_mem_hilo_stage #(.WIDTH(32), .REG_ADDR_W(5)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .High(High), .Low(Low),
    .ZeroFlag(ZeroFlag), .HiLoWrite(HiLoWrite), .MoveOp(MoveOp),
    .MoveData(MoveData), .ReadSel(ReadSel), .RegWriteIn(RegWriteIn),
    .DestRegIn(DestRegIn), .Stall(Stall), .Flush(Flush),
    .OutValid(OutValid), .Result(Result), .ZeroOut(ZeroOut),
    .RegWriteOut(RegWriteOut), .DestRegOut(DestRegOut),
`ifdef EXMEM_PERF_CNT_EN
    .RetireCount(RetireCount), .StallCount(StallCount),
`endif
    .HiReg(HiReg), .LoReg(LoReg)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chkPipe(input string tag, input logic v, input logic [31:0] r,
                         input logic z, input logic rw, input logic [4:0] d);
    chk({tag, ".valid"}, {31'd0, OutValid}, {31'd0, v});
    chk({tag, ".result"}, Result, r);
    chk({tag, ".zero"}, {31'd0, ZeroOut}, {31'd0, z});
    chk({tag, ".regwr"}, {31'd0, RegWriteOut}, {31'd0, rw});
    chk({tag, ".dest"}, {27'd0, DestRegOut}, {27'd0, d});
  endtask

  task automatic chkHiLo(input string tag, input logic [31:0] h, input logic [31:0] l);
    chk({tag, ".hi"}, HiReg, h);
    chk({tag, ".lo"}, LoReg, l);
  endtask

  initial begin
    Reset = 1'b1; InValid = 1'b1; High = 32'h1111; Low = 32'h2222;
    ZeroFlag = 1'b1; HiLoWrite = 1'b1; MoveOp = 2'b00; MoveData = 32'h0;
    ReadSel = 2'b00; RegWriteIn = 1'b1; DestRegIn = 5'd7; Stall = 1'b0; Flush = 1'b0;
    #2;

    // reset held for two cycles with a live mult
    step(); step();
    chkPipe("reset", 1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
    chkHiLo("reset", 32'h0, 32'h0);

    // MULT
    Reset = 1'b0; High = 32'h1; Low = 32'hFFFF_FFFE; ZeroFlag = 1'b0;
    RegWriteIn = 1'b0; DestRegIn = 5'd0;
    step();
    chkPipe("mult", 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 5'd0);
    chkHiLo("mult", 32'h1, 32'hFFFF_FFFE);

    // MFHI back to back
    HiLoWrite = 1'b0; ReadSel = 2'b01; RegWriteIn = 1'b1; DestRegIn = 5'd3; Low = 32'hDEAD;
    step();
    chkPipe("mfhi", 1'b1, 32'h1, 1'b0, 1'b1, 5'd3);

    // MFLO combined with a mult write: result is the old LO
    HiLoWrite = 1'b1; High = 32'h77; Low = 32'h88; ReadSel = 2'b10; DestRegIn = 5'd4;
    step();
    chkPipe("mflo_rw", 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, 5'd4);
    chkHiLo("mflo_rw", 32'h77, 32'h88);

    // ReadSel 11 selects Low, ZeroFlag passes through
    HiLoWrite = 1'b0; ReadSel = 2'b11; Low = 32'h55; ZeroFlag = 1'b1; DestRegIn = 5'd5;
    step();
    chkPipe("sel11", 1'b1, 32'h55, 1'b1, 1'b1, 5'd5);
    chkHiLo("sel11", 32'h77, 32'h88);

    // MTLO together with HiLoWrite: HiLoWrite wins
    ReadSel = 2'b00; ZeroFlag = 1'b0; MoveOp = 2'b10; MoveData = 32'hCAFE_F00D;
    HiLoWrite = 1'b1; High = 32'h9; Low = 32'h5;
    step();
    chkHiLo("mtlo_hlw", 32'h9, 32'h5);
    chk("mtlo_hlw.result", Result, 32'h5);

    // MTLO alone
    HiLoWrite = 1'b0; Low = 32'h66;
    step();
    chkHiLo("mtlo", 32'h9, 32'hCAFE_F00D);
    chk("mtlo.result", Result, 32'h66);

    // MTHI
    MoveOp = 2'b01; MoveData = 32'h1234_5678;
    step();
    chkHiLo("mthi", 32'h1234_5678, 32'hCAFE_F00D);

    // MoveOp 11 is a no-op
    MoveOp = 2'b11; MoveData = 32'hFFFF;
    step();
    chkHiLo("move11", 32'h1234_5678, 32'hCAFE_F00D);

    // instruction to be held by the stall
    MoveOp = 2'b00; Low = 32'h1234; RegWriteIn = 1'b1; DestRegIn = 5'd9;
    step();
    chkPipe("prestall", 1'b1, 32'h1234, 1'b0, 1'b1, 5'd9);

    // stall + flush for three cycles with new inputs
    Stall = 1'b1; Flush = 1'b1; Low = 32'hBEEF; HiLoWrite = 1'b1; High = 32'hAAAA;
    DestRegIn = 5'd2; ZeroFlag = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chkPipe("stall", 1'b1, 32'h1234, 1'b0, 1'b1, 5'd9);
      chkHiLo("stall", 32'h1234_5678, 32'hCAFE_F00D);
    end

    // release: held-back instruction captured
    Stall = 1'b0; Flush = 1'b0;
    step();
    chkPipe("release", 1'b1, 32'hBEEF, 1'b1, 1'b1, 5'd2);
    chkHiLo("release", 32'hAAAA, 32'hBEEF);

    // flush
    Flush = 1'b1; High = 32'hAA; Low = 32'hBB; DestRegIn = 5'd6;
    step();
    chkPipe("flush", 1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
    chkHiLo("flush", 32'hAAAA, 32'hBEEF);

    // bubble from InValid=0
    Flush = 1'b0; InValid = 1'b0;
    step();
    chkPipe("bubble", 1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
    chkHiLo("bubble", 32'hAAAA, 32'hBEEF);

    // reset during a stall discards the held instruction
    InValid = 1'b1; HiLoWrite = 1'b0; Low = 32'h42; ZeroFlag = 1'b0; DestRegIn = 5'd8;
    step();
    chkPipe("prereset", 1'b1, 32'h42, 1'b0, 1'b1, 5'd8);
    Stall = 1'b1; Reset = 1'b1;
    step();
    chkPipe("rststall", 1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
    chkHiLo("rststall", 32'h0, 32'h0);

`ifdef EXMEM_PERF_CNT_EN
    chk("perf_rst.retire", RetireCount, 32'd0);
    chk("perf_rst.stall", StallCount, 32'd0);
    Reset = 1'b0; Stall = 1'b0;
    for (int i = 0; i < 5; i++) step();
    Stall = 1'b1;
    for (int i = 0; i < 2; i++) step();
    Stall = 1'b0; InValid = 1'b0;
    step();
    chk("perf.retire", RetireCount, 32'd5);
    chk("perf.stall", StallCount, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
